mmc1_banked_mapper: RTL and testbench
=====================================

# mmc1_banked_mapper

Parametrised next-generation MMC1 mapper for the Famicom cartridge CPLD. It sits between the CPU/PPU buses and the PRG ROM, CHR ROM/RAM and WRAM address pins. It implements the 5-write serial register load with a consecutive-write filter, plus synchronous reset. Bank widths, WRAM banking and an optional 512 KB PRG outer bank are configurable, which lets one block cover SNROM/SOROM/SUROM-class boards.

## Interface
- PRG_BITS, 4: PRG 16 KB bank address bits driven (PRG_A14 upward); legal 1..5.
- CHR_BITS, 5: CHR 4 KB bank address bits driven (CHR_A12 upward); legal 1..5.
- WRAM_BITS, 2: WRAM 8 KB bank bits taken from CHR bank 0 bits [3:2]; legal 1..2.
- Clock and reset (already decided): one clock, CPU_M2; reset nRST is synchronous and active-low.
- CPU_M2  in  1  clock; all registers update on its falling edge
- nRST  in  1  synchronous active-low reset, sampled on the CPU_M2 falling edge
- CPU_A  in  2  CPU A[14:13]
- nCPU_ROMSEL  in  1  active-low $8000-$FFFF select
- nCPU_RW  in  1  low = CPU write
- CPU_D0, CPU_D7  in  1 each  serial data bit; load-reset bit
- PPU_A12, PPU_A11, PPU_A10  in  1 each  PPU address
- CIRAM_A10  out  1  nametable select
- PRG_A  out  PRG_BITS  PRG ROM A14 and up
- nPRG_CE  out  1  PRG ROM enable, active-low
- CHR_A  out  CHR_BITS  CHR A12 and up
- WRAM_A  out  WRAM_BITS  WRAM A13 and up
- nWRAM_CE  out  1  WRAM enable, active-low

## Operation
**Write detection**
- wr = !nCPU_ROMSEL && !nCPU_RW, sampled at the falling edge of CPU_M2.
- A write is accepted only if wr was 0 on the previous edge. The second write of a read-modify-write pair is ignored.
- The filter applies to both D7 writes and data writes.

**D7 reset write**
- Clears the shift register and the 3-bit count to 0.
- Sets Control[3:2] = 11; all other Control bits are unchanged.

**Data write**
- count < 4: shift D0 into bit 3 of the 4-bit shift register and increment count.
- count = 4: commit {D0, shift[3:0]} to the register selected by CPU_A:
  - 00 = Control
  - 01 = CHR0
  - 10 = CHR1
  - 11 = PRG
- After a commit, count and shift return to 0.

**Reset values**
- Control = 5'b01100; CHR0 = CHR1 = PRG = 0; count = 0; filter flag = 0.
- nRST has priority over any concurrent write; a partially shifted sequence is discarded.

**Mirroring (Control[1:0])**
- 00 → CIRAM_A10 = 0
- 01 → CIRAM_A10 = 1
- 10 → CIRAM_A10 = PPU_A10
- 11 → CIRAM_A10 = PPU_A11

**PRG mapping**
- Inner bits p = PRG[3:0], truncated to min(PRG_BITS, 4).
- Mode 0x/1x with Control[3] = 0: {p[..:1], CPU_A14}.
- Mode 10: CPU_A14 = 0 → 0; CPU_A14 = 1 → p.
- Mode 11: CPU_A14 = 1 → all ones; CPU_A14 = 0 → p.
- PRG_A[4] (only when PRG_BITS = 5) is set per Configuration.

**Other outputs**
- nPRG_CE = nCPU_ROMSEL || !nCPU_RW.
- nWRAM_CE = !(CPU_M2 && nCPU_ROMSEL && CPU_A[1] && CPU_A[0] && !PRG[4]).
- WRAM_A = CHR0[3:2] (low WRAM_BITS bits).
- CHR with Control[4] = 1 (4 KB mode): PPU_A12 ? CHR1 : CHR0.
- CHR with Control[4] = 0 (8 KB mode): {CHR0[..:1], PPU_A12}.

## Timing
- All outputs are combinational from registers and live bus inputs; no output registers. CHR, CIRAM and PRG follow PPU_A12/A11/A10 and CPU_A14 with zero clock latency.
- A committed register value is visible immediately after the falling edge of the fifth accepted write.
- Outputs after reset (mode 11, mirroring 00, WRAM enabled):
  - PRG_A = all ones when CPU_A14 = 1, 0 when CPU_A14 = 0.
  - CHR_A = {0, PPU_A12}.
  - CIRAM_A10 = 0.
- Only one write can occur per edge, so writes never collide with each other. A reset edge overrides a write on the same edge.

## Configuration
- MMC1_PRG_OUTER_EN defined, PRG_BITS = 5: PRG_A[4] = CHR0[4], with 4 KB mode using the register selected by PPU_A12. This bit is excluded from the mode-11 all-ones forcing.
- MMC1_PRG_OUTER_EN undefined: PRG_A[4] = 0 and CHR0[4]/CHR1[4] affect CHR only.

## Structure
- Package mmc1_pkg holds:
  - mirroring and PRG-mode enums;
  - register-select codes;
  - reset constants (CONTROL_RST = 5'b01100).
- Sub-module mmc1_serial_loader contains the write filter, shift register and count. Its outputs are commit strobe, 2-bit select, 5-bit value and the D7-reset strobe.

## Test plan
- Reset: hold nRST low for 1 edge → CPU_A14=1 gives PRG_A=4'hF, CPU_A14=0 gives 0, CIRAM_A10=0, nWRAM_CE low at $6000 with M2 high.
- Write $E000 D0=1,0,1,0,0 on non-adjacent cycles → PRG=5'b00101; CPU_A14=0 gives PRG_A=4'h5.
- Write D0=1 on two adjacent M2 cycles → only one shift accepted (count=1); a complete 5-write sequence then needs 4 more writes.
- Control=5'b10011, then 3 data writes, then a D7 write → count=0, Control=5'b11111; the next 5 writes commit normally.
- Control=5'b10000, CHR0=5'h03, CHR1=5'h1A → PPU_A12=0 gives CHR_A=5'h03, PPU_A12=1 gives 5'h1A. Control=0, same CHR0 → CHR_A = 5'h02 / 5'h03.
- nRST low on the edge of the 3rd write → all registers at reset values; the next 5 writes to $A000 commit CHR0.
- PRG_BITS=5, CHR0=5'h10, mode 11, CPU_A14=1 → with MMC1_PRG_OUTER_EN PRG_A=5'h1F, without it 5'h0F.

Source files
------------

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 banked mapper: register codes, mode
// encodings and the reset value of the control register.
package mmc1_pkg;

    typedef enum logic [1:0] {
        MIRROR_SINGLE_LO  = 2'b00,
        MIRROR_SINGLE_HI  = 2'b01,
        MIRROR_VERTICAL   = 2'b10,
        MIRROR_HORIZONTAL = 2'b11
    } mirror_e;

    typedef enum logic [1:0] {
        PRG_MODE_32K_0     = 2'b00,
        PRG_MODE_32K_1     = 2'b01,
        PRG_MODE_FIX_FIRST = 2'b10,
        PRG_MODE_FIX_LAST  = 2'b11
    } prg_mode_e;

    typedef enum logic [1:0] {
        SEL_CONTROL = 2'b00,
        SEL_CHR0    = 2'b01,
        SEL_CHR1    = 2'b10,
        SEL_PRG     = 2'b11
    } reg_sel_e;

    localparam logic [4:0] CONTROL_RST = 5'b01100;
    localparam logic [4:0] BANK_RST    = 5'b00000;
    localparam logic [2:0] LOAD_LAST   = 3'd4;

    function automatic int unsigned min_bits(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mmc1_banked_mapper_if.sv
// Cartridge-edge bus of the MMC1 mapper: CPU/PPU inputs and ROM/RAM address outputs.
// The master side is the console buses, the slave side is the mapper.
interface mmc1_banked_mapper_if #(
    parameter int unsigned PRG_BITS  = 4,
    parameter int unsigned CHR_BITS  = 5,
    parameter int unsigned WRAM_BITS = 2
);
    logic [1:0]           CPU_A;
    logic                 nCPU_ROMSEL;
    logic                 nCPU_RW;
    logic                 CPU_D0;
    logic                 CPU_D7;
    logic                 PPU_A12;
    logic                 PPU_A11;
    logic                 PPU_A10;
    logic                 CIRAM_A10;
    logic [PRG_BITS-1:0]  PRG_A;
    logic                 nPRG_CE;
    logic [CHR_BITS-1:0]  CHR_A;
    logic [WRAM_BITS-1:0] WRAM_A;
    logic                 nWRAM_CE;

    modport master (
        output CPU_A, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7, PPU_A12, PPU_A11, PPU_A10,
        input  CIRAM_A10, PRG_A, nPRG_CE, CHR_A, WRAM_A, nWRAM_CE
    );

    modport slave (
        input  CPU_A, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7, PPU_A12, PPU_A11, PPU_A10,
        output CIRAM_A10, PRG_A, nPRG_CE, CHR_A, WRAM_A, nWRAM_CE
    );

endinterface

// File: rtl/mmc1_serial_loader.sv
// MMC1 5-write serial loader: consecutive-write filter, 4-bit shift register and
// count. Emits a commit strobe with target/value and a D7-reset strobe.
module mmc1_serial_loader
    import mmc1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic [1:0] addr_i,
    input  logic       d0_i,
    input  logic       d7_i,
    output logic       commit_o,
    output reg_sel_e   sel_o,
    output logic [4:0] value_o,
    output logic       d7_rst_o
);

    logic       wr_prev_q;
    logic [3:0] shift_q, shift_d;
    logic [2:0] count_q, count_d;
    logic       accept;

    // The second cycle of a read-modify-write pair sees wr still high and is dropped.
    assign accept = wr_i && !wr_prev_q;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        commit_o = 1'b0;
        d7_rst_o = 1'b0;
        sel_o    = reg_sel_e'(addr_i);
        value_o  = {d0_i, shift_q};
        if (accept) begin
            if (d7_i) begin
                d7_rst_o = 1'b1;
                shift_d  = '0;
                count_d  = '0;
            end else if (count_q == LOAD_LAST) begin
                commit_o = 1'b1;
                shift_d  = '0;
                count_d  = '0;
            end else begin
                shift_d = {d0_i, shift_q[3:1]};
                count_d = count_q + 3'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            wr_prev_q <= 1'b0;
            shift_q   <= '0;
            count_q   <= '0;
        end else begin
            wr_prev_q <= wr_i;
            shift_q   <= shift_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/mmc1_banked_mapper.sv
// MMC1 banked mapper top: register file, PRG/CHR/WRAM banking and mirroring.
// Define MMC1_PRG_OUTER_EN (with PRG_BITS = 5) to drive PRG_A[4] from the CHR bank bit 4.
module mmc1_banked_mapper
    import mmc1_pkg::*;
#(
    parameter int unsigned PRG_BITS  = 4,
    parameter int unsigned CHR_BITS  = 5,
    parameter int unsigned WRAM_BITS = 2
) (
    input  logic                 CPU_M2,
    input  logic                 nRST,
    mmc1_banked_mapper_if.slave  bus
);

    localparam int unsigned PRG_INNER = min_bits(PRG_BITS, 4);

    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;

    logic       wr;
    logic       commit;
    reg_sel_e   commit_sel;
    logic [4:0] commit_value;
    logic       d7_rst;

    assign wr = !bus.nCPU_ROMSEL && !bus.nCPU_RW;

    mmc1_serial_loader u_loader (
        .clk      (CPU_M2),
        .rst_n    (nRST),
        .wr_i     (wr),
        .addr_i   (bus.CPU_A),
        .d0_i     (bus.CPU_D0),
        .d7_i     (bus.CPU_D7),
        .commit_o (commit),
        .sel_o    (commit_sel),
        .value_o  (commit_value),
        .d7_rst_o (d7_rst)
    );

    always_comb begin
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        if (d7_rst) begin
            control_d[3:2] = 2'b11;
        end else if (commit) begin
            unique case (commit_sel)
                SEL_CONTROL: control_d = commit_value;
                SEL_CHR0:    chr0_d    = commit_value;
                SEL_CHR1:    chr1_d    = commit_value;
                SEL_PRG:     prg_d     = commit_value;
                default:     prg_d     = prg_q;
            endcase
        end
    end

    always_ff @(negedge CPU_M2) begin
        if (!nRST) begin
            control_q <= CONTROL_RST;
            chr0_q    <= BANK_RST;
            chr1_q    <= BANK_RST;
            prg_q     <= BANK_RST;
        end else begin
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
        end
    end

    logic       a14;
    logic [3:0] prg_bank;
    logic [4:0] chr_bank;

    assign a14 = bus.CPU_A[1];

    always_comb begin
        unique case (prg_mode_e'(control_q[3:2]))
            PRG_MODE_FIX_FIRST: prg_bank = a14 ? prg_q[3:0] : 4'h0;
            PRG_MODE_FIX_LAST:  prg_bank = a14 ? 4'hF : prg_q[3:0];
            default:            prg_bank = {prg_q[3:1], a14};
        endcase
    end

    always_comb begin
        if (control_q[4]) begin
            chr_bank = bus.PPU_A12 ? chr1_q : chr0_q;
        end else begin
            chr_bank = {chr0_q[4:1], bus.PPU_A12};
        end
    end

    always_comb begin
        unique case (mirror_e'(control_q[1:0]))
            MIRROR_SINGLE_LO:  bus.CIRAM_A10 = 1'b0;
            MIRROR_SINGLE_HI:  bus.CIRAM_A10 = 1'b1;
            MIRROR_VERTICAL:   bus.CIRAM_A10 = bus.PPU_A10;
            MIRROR_HORIZONTAL: bus.CIRAM_A10 = bus.PPU_A11;
            default:           bus.CIRAM_A10 = 1'b0;
        endcase
    end

    // The outer 256 KB bit sits above the inner bank and is never forced by mode 11.
    generate
        if (PRG_BITS > 4) begin : g_prg_outer
            logic prg_outer;
`ifdef MMC1_PRG_OUTER_EN
            assign prg_outer = (control_q[4] && bus.PPU_A12) ? chr1_q[4] : chr0_q[4];
`else
            assign prg_outer = 1'b0;
`endif
            assign bus.PRG_A = {prg_outer, prg_bank};
        end else begin : g_prg_inner
            assign bus.PRG_A = prg_bank[PRG_INNER-1:0];
        end
    endgenerate

    assign bus.CHR_A    = chr_bank[CHR_BITS-1:0];
    assign bus.WRAM_A   = chr0_q[WRAM_BITS+1:2];
    assign bus.nPRG_CE  = bus.nCPU_ROMSEL || !bus.nCPU_RW;
    assign bus.nWRAM_CE = !(CPU_M2 && bus.nCPU_ROMSEL && bus.CPU_A[1] && bus.CPU_A[0] && !prg_q[4]);

endmodule

// File: tb/tb_mmc1_banked_mapper.sv
// Directed bench for mmc1_banked_mapper: a default 4-bit PRG instance and a 5-bit PRG
// instance share one bus stimulus; expected values are hand-computed constants.
module tb_mmc1_banked_mapper;
    import mmc1_pkg::*;

    logic cpu_m2;
    logic n_rst;
    int   n_checks;
    int   n_fails;

    mmc1_banked_mapper_if #(.PRG_BITS(4), .CHR_BITS(5), .WRAM_BITS(2)) bus4 ();
    mmc1_banked_mapper_if #(.PRG_BITS(5), .CHR_BITS(5), .WRAM_BITS(2)) bus5 ();

    assign bus5.CPU_A       = bus4.CPU_A;
    assign bus5.nCPU_ROMSEL = bus4.nCPU_ROMSEL;
    assign bus5.nCPU_RW     = bus4.nCPU_RW;
    assign bus5.CPU_D0      = bus4.CPU_D0;
    assign bus5.CPU_D7      = bus4.CPU_D7;
    assign bus5.PPU_A12     = bus4.PPU_A12;
    assign bus5.PPU_A11     = bus4.PPU_A11;
    assign bus5.PPU_A10     = bus4.PPU_A10;

    mmc1_banked_mapper #(.PRG_BITS(4), .CHR_BITS(5), .WRAM_BITS(2)) dut4 (
        .CPU_M2 (cpu_m2),
        .nRST   (n_rst),
        .bus    (bus4)
    );

    mmc1_banked_mapper #(.PRG_BITS(5), .CHR_BITS(5), .WRAM_BITS(2)) dut5 (
        .CPU_M2 (cpu_m2),
        .nRST   (n_rst),
        .bus    (bus5)
    );

    initial cpu_m2 = 1'b0;
    always #10 cpu_m2 = ~cpu_m2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus4.nCPU_ROMSEL = 1'b1;
        bus4.nCPU_RW     = 1'b1;
        bus4.CPU_D0      = 1'b0;
        bus4.CPU_D7      = 1'b0;
    endtask

    // One accepted write followed by one idle edge so the filter flag clears.
    task automatic cpu_write(input logic [1:0] sel, input logic d0, input logic d7);
        @(posedge cpu_m2); #1;
        bus4.CPU_A       = sel;
        bus4.nCPU_ROMSEL = 1'b0;
        bus4.nCPU_RW     = 1'b0;
        bus4.CPU_D0      = d0;
        bus4.CPU_D7      = d7;
        @(negedge cpu_m2); #1;
        bus_idle();
        @(negedge cpu_m2); #1;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [4:0] value);
        for (int i = 0; i < 5; i++) cpu_write(sel, value[i], 1'b0);
    endtask

    // Read-cycle bus state while M2 is high; no write is generated.
    task automatic probe(input logic [1:0] cpu_a, input logic romsel_n,
                         input logic a12, input logic a11, input logic a10);
        @(posedge cpu_m2); #2;
        bus4.CPU_A       = cpu_a;
        bus4.nCPU_ROMSEL = romsel_n;
        bus4.nCPU_RW     = 1'b1;
        bus4.PPU_A12     = a12;
        bus4.PPU_A11     = a11;
        bus4.PPU_A10     = a10;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        n_rst    = 1'b0;
        bus4.CPU_A   = 2'b00;
        bus4.PPU_A12 = 1'b0;
        bus4.PPU_A11 = 1'b0;
        bus4.PPU_A10 = 1'b0;
        bus_idle();
        @(negedge cpu_m2); #1;
        n_rst = 1'b1;

        // Reset state
        probe(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_prg_a14_1", bus4.PRG_A, 4'hF);
        check("rst_prg5_a14_1", bus5.PRG_A, 5'h0F);
        check("rst_ciram", bus4.CIRAM_A10, 1'b0);
        check("rst_chr", bus4.CHR_A, 5'h01);
        check("rd_nprg_ce", bus4.nPRG_CE, 1'b0);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_prg_a14_0", bus4.PRG_A, 4'h0);
        probe(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_wram_ce_m2hi", bus4.nWRAM_CE, 1'b0);
        @(negedge cpu_m2); #2;
        check("wram_ce_m2lo", bus4.nWRAM_CE, 1'b1);

        // PRG load $E000 with 1,0,1,0,0
        write_reg(2'b11, 5'b00101);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prg5_a14_0", bus4.PRG_A, 4'h5);
        probe(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prg5_a14_1", bus4.PRG_A, 4'hF);

        // Adjacent write pair: only the first is shifted
        @(posedge cpu_m2); #1;
        bus4.CPU_A       = 2'b11;
        bus4.nCPU_ROMSEL = 1'b0;
        bus4.nCPU_RW     = 1'b0;
        bus4.CPU_D0      = 1'b1;
        bus4.CPU_D7      = 1'b0;
        #3;
        check("wr_nprg_ce", bus4.nPRG_CE, 1'b1);
        @(negedge cpu_m2); #1;
        @(negedge cpu_m2); #1;
        bus_idle();
        @(negedge cpu_m2); #1;
        cpu_write(2'b11, 1'b0, 1'b0);
        cpu_write(2'b11, 1'b1, 1'b0);
        cpu_write(2'b11, 1'b1, 1'b0);
        cpu_write(2'b11, 1'b0, 1'b0);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("filter_prg", bus4.PRG_A, 4'hD);

        // Control = 10011 (32 KB mode, horizontal), then partial load aborted by D7
        write_reg(2'b00, 5'b10011);
        probe(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mode32_a14_1", bus4.PRG_A, 4'hD);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mode32_a14_0", bus4.PRG_A, 4'hC);
        cpu_write(2'b00, 1'b1, 1'b0);
        cpu_write(2'b00, 1'b1, 1'b0);
        cpu_write(2'b00, 1'b1, 1'b0);
        cpu_write(2'b00, 1'b0, 1'b1);
        probe(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        check("d7_mode11", bus4.PRG_A, 4'hF);
        check("mirror_h_a11_1", bus4.CIRAM_A10, 1'b1);
        probe(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mirror_h_a11_0", bus4.CIRAM_A10, 1'b0);
        write_reg(2'b11, 5'b00011);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_d7_prg", bus4.PRG_A, 4'h3);

        // CHR 4 KB and 8 KB modes
        write_reg(2'b00, 5'b10000);
        write_reg(2'b01, 5'h03);
        write_reg(2'b10, 5'h1A);
        probe(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("chr4k_a12_0", bus4.CHR_A, 5'h03);
        check("mirror_lo", bus4.CIRAM_A10, 1'b0);
        probe(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("chr4k_a12_1", bus4.CHR_A, 5'h1A);
        write_reg(2'b00, 5'b00000);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("chr8k_a12_0", bus4.CHR_A, 5'h02);
        probe(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("chr8k_a12_1", bus4.CHR_A, 5'h03);
        check("mode32_prg3", bus4.PRG_A, 4'h3);

        // Reset on the edge of the third write of a CHR0 load
        cpu_write(2'b01, 1'b1, 1'b0);
        cpu_write(2'b01, 1'b1, 1'b0);
        @(posedge cpu_m2); #1;
        bus4.CPU_A       = 2'b01;
        bus4.nCPU_ROMSEL = 1'b0;
        bus4.nCPU_RW     = 1'b0;
        bus4.CPU_D0      = 1'b1;
        n_rst            = 1'b0;
        @(negedge cpu_m2); #1;
        n_rst = 1'b1;
        bus_idle();
        @(negedge cpu_m2); #1;
        probe(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rst2_prg_a14_1", bus4.PRG_A, 4'hF);
        check("rst2_chr", bus4.CHR_A, 5'h01);
        check("rst2_ciram", bus4.CIRAM_A10, 1'b0);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst2_prg_a14_0", bus4.PRG_A, 4'h0);
        write_reg(2'b01, 5'h0D);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("chr0_after_rst_a12_0", bus4.CHR_A, 5'h0C);
        check("wram_a", bus4.WRAM_A, 2'b11);
        probe(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("chr0_after_rst_a12_1", bus4.CHR_A, 5'h0D);

        // PRG outer bank bit on the 5-bit instance
        write_reg(2'b01, 5'h10);
        probe(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("outer4_a14_1", bus4.PRG_A, 4'hF);
`ifdef MMC1_PRG_OUTER_EN
        check("outer5_8k", bus5.PRG_A, 5'h1F);
`else
        check("outer5_8k", bus5.PRG_A, 5'h0F);
`endif
        write_reg(2'b10, 5'h05);
        write_reg(2'b00, 5'b11100);
        probe(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("chr4k_chr1", bus4.CHR_A, 5'h05);
        check("outer5_4k_a12_1", bus5.PRG_A, 5'h0F);
        probe(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MMC1_PRG_OUTER_EN
        check("outer5_4k_a12_0", bus5.PRG_A, 5'h1F);
`else
        check("outer5_4k_a12_0", bus5.PRG_A, 5'h0F);
`endif

        // WRAM disable via PRG[4]
        write_reg(2'b11, 5'h10);
        probe(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wram_disabled", bus4.nWRAM_CE, 1'b1);
        probe(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prg_bit4_inner0", bus4.PRG_A, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
